// File: rtl/ex_muldiv_unit_if.sv
// Operand/result bundle between the EX stage and the RV32M multiply/divide unit.
// start is a request sampled only while the unit is idle, and done is a one-cycle result-valid pulse (no ready/back-pressure).
interface ex_muldiv_unit_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [2:0]       funct3;
    logic [WIDTH-1:0] op1;
    logic [WIDTH-1:0] op2;
    logic             flush;
    logic             busy;
    logic             stall_req;
    logic             done;
    logic [WIDTH-1:0] result;

    modport master (
        output start, funct3, op1, op2, flush,
        input  busy, stall_req, done, result
    );

    modport slave (
        input  start, funct3, op1, op2, flush,
        output busy, stall_req, done, result
    );
endinterface

// File: rtl/ex_muldiv_unit.sv
// Multi-cycle RV32M multiply/divide unit: shift-add multiplier and restoring divider on magnitudes.
// Define MULDIV_FAST_MUL_EN to replace the iterative multiplier with a single-cycle combinational one.
module ex_muldiv_unit #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic            clk,
    input  logic            rst,
    ex_muldiv_unit_if.slave mdu,
    output logic [1:0]      dbg_state
);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_MUL  = 2'd1;
    localparam logic [1:0] S_DIV  = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;
    localparam logic [WIDTH-1:0] INT_MIN = {1'b1, {(WIDTH-1){1'b0}}};

    logic [1:0]         state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0]   rem_q, rem_d;
    logic [WIDTH-1:0]   opnd_q, opnd_d;
    logic [WIDTH-1:0]   result_q, result_d;
    logic [1:0]         funct_q, funct_d;
    logic               s1_q, s1_d, s2_q, s2_d;

    // MUL is treated as signed*signed; its low half is identical for any signedness.
    logic             in_signed1, in_signed2, in_s1, in_s2, div_zero, div_ovf;
    logic [WIDTH-1:0] mag1, mag2, special_res;
    assign in_signed1  = mdu.funct3[2] ? ~mdu.funct3[0] : (mdu.funct3[1:0] != 2'b11);
    assign in_signed2  = mdu.funct3[2] ? ~mdu.funct3[0] : ~mdu.funct3[1];
    assign in_s1       = in_signed1 & mdu.op1[WIDTH-1];
    assign in_s2       = in_signed2 & mdu.op2[WIDTH-1];
    assign mag1        = in_s1 ? -mdu.op1 : mdu.op1;
    assign mag2        = in_s2 ? -mdu.op2 : mdu.op2;
    assign div_zero    = (mdu.op2 == '0);
    assign div_ovf     = ~mdu.funct3[0] & (mdu.op1 == INT_MIN) & (mdu.op2 == '1);
    assign special_res = div_zero ? (mdu.funct3[1] ? mdu.op1 : '1)
                                  : (mdu.funct3[1] ? '0 : INT_MIN);

    // acc holds {partial product, multiplier} for MUL and {unused, dividend/quotient} for DIV.
    logic [WIDTH:0]     mul_sum, rem_shift, rem_trial;
    logic               div_ge;
    logic [2*WIDTH-1:0] mul_next;
    logic [WIDTH-1:0]   quo_next, rem_next;
    assign mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, {WIDTH{acc_q[0]}} & opnd_q};
    assign mul_next  = {mul_sum, acc_q[WIDTH-1:1]};
    assign rem_shift = {rem_q, acc_q[WIDTH-1]};
    assign rem_trial = rem_shift - {1'b0, opnd_q};
    assign div_ge    = ~rem_trial[WIDTH];
    assign quo_next  = {acc_q[WIDTH-2:0], div_ge};
    assign rem_next  = div_ge ? rem_trial[WIDTH-1:0] : rem_shift[WIDTH-1:0];

`ifdef MULDIV_FAST_MUL_EN
    logic [2*WIDTH-1:0] fast_prod;
    assign fast_prod = {{WIDTH{1'b0}}, mag1} * {{WIDTH{1'b0}}, mag2};
`endif

    function automatic logic [WIDTH-1:0] mul_select(input logic [2*WIDTH-1:0] p,
                                                    input logic [1:0] f, input logic neg);
        logic [2*WIDTH-1:0] sp;
        sp = neg ? -p : p;
        return (f == 2'b00) ? sp[WIDTH-1:0] : sp[2*WIDTH-1:WIDTH];
    endfunction

    function automatic logic [WIDTH-1:0] div_select(input logic [WIDTH-1:0] q, input logic [WIDTH-1:0] r,
                                                    input logic is_rem, input logic s1, input logic s2);
        if (is_rem) return s1 ? -r : r;
        return (s1 ^ s2) ? -q : q;
    endfunction

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        rem_d    = rem_q;
        opnd_d   = opnd_q;
        result_d = result_q;
        funct_d  = funct_q;
        s1_d     = s1_q;
        s2_d     = s2_q;
        case (state_q)
            S_IDLE: begin
                if (mdu.start) begin
                    funct_d = mdu.funct3[1:0];
                    s1_d    = in_s1;
                    s2_d    = in_s2;
                    cnt_d   = '0;
                    rem_d   = '0;
                    if (!mdu.funct3[2]) begin
`ifdef MULDIV_FAST_MUL_EN
                        state_d  = S_DONE;
                        result_d = mul_select(fast_prod, mdu.funct3[1:0], in_s1 ^ in_s2);
`else
                        state_d = S_MUL;
                        acc_d   = {{WIDTH{1'b0}}, mag2};
                        opnd_d  = mag1;
`endif
                    end else if (div_zero || div_ovf) begin
                        state_d  = S_DONE;
                        result_d = special_res;
                    end else begin
                        state_d = S_DIV;
                        acc_d   = {{WIDTH{1'b0}}, mag1};
                        opnd_d  = mag2;
                    end
                end
            end
            S_MUL: begin
                acc_d = mul_next;
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(WIDTH-1)) begin
                    state_d  = S_DONE;
                    result_d = mul_select(mul_next, funct_q, s1_q ^ s2_q);
                end
            end
            S_DIV: begin
                acc_d = {acc_q[2*WIDTH-1:WIDTH], quo_next};
                rem_d = rem_next;
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(WIDTH-1)) begin
                    state_d  = S_DONE;
                    result_d = div_select(quo_next, rem_next, funct_q[1], s1_q, s2_q);
                end
            end
            default: state_d = S_IDLE;
        endcase
        // A killed op must not disturb the result the pipeline last consumed.
        if (mdu.flush) begin
            state_d  = S_IDLE;
            result_d = result_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            acc_q    <= '0;
            rem_q    <= '0;
            opnd_q   <= '0;
            result_q <= '0;
            funct_q  <= '0;
            s1_q     <= 1'b0;
            s2_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            rem_q    <= rem_d;
            opnd_q   <= opnd_d;
            result_q <= result_d;
            funct_q  <= funct_d;
            s1_q     <= s1_d;
            s2_q     <= s2_d;
        end
    end

    assign mdu.busy      = (state_q != S_IDLE);
    assign mdu.done      = (state_q == S_DONE);
    assign mdu.stall_req = ((state_q == S_IDLE) & mdu.start & ~mdu.flush)
                         | (state_q == S_MUL) | (state_q == S_DIV);
    assign mdu.result    = result_q;
    assign dbg_state     = state_q;
endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Directed bench for ex_muldiv_unit: vector table for results/latency plus flush, reset and held-start sequences.
`timescale 1ns/1ps
module tb_ex_muldiv_unit;
    localparam int W = 32;
`ifdef MULDIV_FAST_MUL_EN
    localparam int MUL_LAT = 1;
`else
    localparam int MUL_LAT = 33;
`endif
    localparam int DIV_LAT = 33;
    localparam int SPC_LAT = 1;
    localparam int NV = 24;

    typedef struct {
        logic [2:0]   f;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] exp;
        int           lat;
    } vec_t;

    logic       clk;
    logic       rst;
    logic [1:0] dbg_state;
    int         n_checks;
    int         n_fail;
    logic [W-1:0] exp_q[$];
    vec_t       vecs[NV];

    ex_muldiv_unit_if #(.WIDTH(W)) mdu_if ();

    ex_muldiv_unit #(.WIDTH(W), .CNT_W(6)) dut (
        .clk       (clk),
        .rst       (rst),
        .mdu       (mdu_if),
        .dbg_state (dbg_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Issues one op, scrambles the operand inputs while busy, waits for done (bounded).
    task automatic run_op(input logic [2:0] f, input logic [W-1:0] a, input logic [W-1:0] b,
                          output logic [W-1:0] res, output int lat,
                          output logic stall_done, output logic busy_done);
        @(negedge clk);
        mdu_if.start = 1'b1; mdu_if.funct3 = f; mdu_if.op1 = a; mdu_if.op2 = b;
        @(posedge clk);
        #1;
        mdu_if.start = 1'b0; mdu_if.op1 = $urandom; mdu_if.op2 = $urandom;
        lat = -1; res = '0; stall_done = 1'b1; busy_done = 1'b0;
        for (int n = 1; n <= 100; n++) begin
            @(negedge clk);
            if (mdu_if.done) begin
                lat = n; res = mdu_if.result;
                stall_done = mdu_if.stall_req; busy_done = mdu_if.busy;
                break;
            end
        end
    endtask

    initial begin
        logic [W-1:0] res;
        logic [W-1:0] prev;
        int           lat;
        int           dn;
        int           first;
        logic         sd, bd;

        n_checks = 0; n_fail = 0;
        vecs[0]  = '{3'b000, 32'd7,         32'hFFFF_FFFD, 32'hFFFF_FFEB, MUL_LAT};
        vecs[1]  = '{3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, MUL_LAT};
        vecs[2]  = '{3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, MUL_LAT};
        vecs[3]  = '{3'b010, 32'hFFFF_FFFF, 32'd2,         32'hFFFF_FFFF, MUL_LAT};
        vecs[4]  = '{3'b000, 32'h1234_5678, 32'h10,        32'h2345_6780, MUL_LAT};
        vecs[5]  = '{3'b011, 32'h8000_0000, 32'd4,         32'h0000_0002, MUL_LAT};
        vecs[6]  = '{3'b001, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, MUL_LAT};
        vecs[7]  = '{3'b010, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, MUL_LAT};
        vecs[8]  = '{3'b100, 32'hFFFF_FFEC, 32'd6,         32'hFFFF_FFFD, DIV_LAT};
        vecs[9]  = '{3'b110, 32'hFFFF_FFEC, 32'd6,         32'hFFFF_FFFE, DIV_LAT};
        vecs[10] = '{3'b101, 32'd20,        32'd6,         32'd3,         DIV_LAT};
        vecs[11] = '{3'b100, 32'd7,         32'hFFFF_FFFE, 32'hFFFF_FFFD, DIV_LAT};
        vecs[12] = '{3'b110, 32'd7,         32'hFFFF_FFFE, 32'd1,         DIV_LAT};
        vecs[13] = '{3'b111, 32'd100,       32'd7,         32'd2,         DIV_LAT};
        vecs[14] = '{3'b101, 32'hFFFF_FFFF, 32'd1,         32'hFFFF_FFFF, DIV_LAT};
        vecs[15] = '{3'b100, 32'h8000_0000, 32'd2,         32'hC000_0000, DIV_LAT};
        vecs[16] = '{3'b101, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         DIV_LAT};
        vecs[17] = '{3'b111, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, DIV_LAT};
        vecs[18] = '{3'b100, 32'd3,         32'd5,         32'd0,         DIV_LAT};
        vecs[19] = '{3'b100, 32'd5,         32'd0,         32'hFFFF_FFFF, SPC_LAT};
        vecs[20] = '{3'b111, 32'd5,         32'd0,         32'd5,         SPC_LAT};
        vecs[21] = '{3'b110, 32'hFFFF_FFFB, 32'd0,         32'hFFFF_FFFB, SPC_LAT};
        vecs[22] = '{3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         SPC_LAT};
        vecs[23] = '{3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, SPC_LAT};

        // clock/reset
        rst = 1'b1;
        mdu_if.start = 1'b0; mdu_if.flush = 1'b0; mdu_if.funct3 = '0; mdu_if.op1 = '0; mdu_if.op2 = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("reset_busy",   {31'd0, mdu_if.busy},      '0);
        check("reset_done",   {31'd0, mdu_if.done},      '0);
        check("reset_stall",  {31'd0, mdu_if.stall_req}, '0);
        check("reset_result", mdu_if.result,             '0);
        check("reset_state",  {30'd0, dbg_state},        '0);

        // vector table
        for (int i = 0; i < NV; i++) begin
            exp_q.push_back(vecs[i].exp);
            run_op(vecs[i].f, vecs[i].a, vecs[i].b, res, lat, sd, bd);
            check($sformatf("vec%0d_f%0d_result", i, vecs[i].f), res, exp_q.pop_front());
            check($sformatf("vec%0d_latency", i), lat, vecs[i].lat);
            check($sformatf("vec%0d_stall_at_done", i), {31'd0, sd}, '0);
            check($sformatf("vec%0d_busy_at_done", i), {31'd0, bd}, 32'd1);
        end
        prev = vecs[NV-1].exp;

        // flush in cycle 10 of DIV 100/7
        @(negedge clk);
        mdu_if.start = 1'b1; mdu_if.funct3 = 3'b100; mdu_if.op1 = 32'd100; mdu_if.op2 = 32'd7;
        @(posedge clk);
        #1;
        mdu_if.start = 1'b0;
        dn = 0;
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            if (mdu_if.done) dn++;
            if (c == 5) check("div_stall_mid", {31'd0, mdu_if.stall_req}, 32'd1);
            if (c == 10) mdu_if.flush = 1'b1;
        end
        @(posedge clk);
        #1;
        mdu_if.flush = 1'b0;
        @(negedge clk);
        if (mdu_if.done) dn++;
        check("flush_busy_c11",  {31'd0, mdu_if.busy}, '0);
        check("flush_no_done",   dn, '0);
        check("flush_result",    mdu_if.result, prev);
        run_op(3'b101, 32'd100, 32'd7, res, lat, sd, bd);
        check("restart_divu_result",  res, 32'd14);
        check("restart_divu_latency", lat, DIV_LAT);

        // flush wins over start in the same cycle
        @(negedge clk);
        mdu_if.start = 1'b1; mdu_if.flush = 1'b1; mdu_if.funct3 = 3'b101; mdu_if.op1 = 32'd9; mdu_if.op2 = 32'd2;
        #1;
        check("flush_start_stall", {31'd0, mdu_if.stall_req}, '0);
        @(posedge clk);
        #1;
        mdu_if.start = 1'b0; mdu_if.flush = 1'b0;
        @(negedge clk);
        check("flush_start_busy", {31'd0, mdu_if.busy}, '0);

        // start held through busy: exactly one done
        @(negedge clk);
        mdu_if.start = 1'b1; mdu_if.funct3 = 3'b101; mdu_if.op1 = 32'd20; mdu_if.op2 = 32'd6;
        dn = 0; first = -1;
        for (int c = 1; c <= 45; c++) begin
            @(negedge clk);
            if (mdu_if.done) begin
                dn++;
                if (first < 0) first = c;
                check("held_start_result", mdu_if.result, 32'd3);
                mdu_if.start = 1'b0;
            end
        end
        mdu_if.start = 1'b0;
        check("held_start_done_count", dn, 32'd1);
        check("held_start_latency", first, DIV_LAT);

        // async reset in cycle 5 of MUL
        @(negedge clk);
        mdu_if.start = 1'b1; mdu_if.funct3 = 3'b000; mdu_if.op1 = 32'd7; mdu_if.op2 = 32'hFFFF_FFFD;
        @(posedge clk);
        #1;
        mdu_if.start = 1'b0;
        repeat (4) @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("rst_mid_busy",   {31'd0, mdu_if.busy},      '0);
        check("rst_mid_stall",  {31'd0, mdu_if.stall_req}, '0);
        check("rst_mid_done",   {31'd0, mdu_if.done},      '0);
        check("rst_mid_result", mdu_if.result,             '0);
        @(negedge clk);
        rst = 1'b0;
        run_op(3'b011, 32'h8000_0000, 32'd4, res, lat, sd, bd);
        check("post_rst_mulhu_result",  res, 32'd2);
        check("post_rst_mulhu_latency", lat, MUL_LAT);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
